ov7670_pixel_capture: RTL and testbench

Front-end capture stage for the microgreen classifier. It takes the raw OV7670 parallel bus (D[7:0], PCLK, HREF, VSYNC) and brings it into the system clock domain. It assembles byte pairs into RGB565 pixels and emits a one-cycle-per-pixel stream with coordinates and frame/line markers. It sits directly upstream of the feature-accumulation and BNN stage. That stage consumes `pix_*`, `frame_start`, `frame_end` and `frame_ok` instead of sampling the camera pins itself.

---
 rtl/ov7670_pixel_capture.sv | 202 ++++++++++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture: synchronizes the camera pins into clk and
// assembles byte pairs into RGB565 pixels with coordinates and frame markers.
module ov7670_pixel_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_W     = 320,
    parameter int FRAME_H     = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] cam_d,
    input  logic       cam_pclk,
    input  logic       cam_href,
    input  logic       cam_vsync,
    output logic       pix_valid,
    output logic [4:0] pix_r,
    output logic [5:0] pix_g,
    output logic [4:0] pix_b,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       frame_start,
    output logic       line_end,
    output logic       frame_end,
    output logic       frame_ok,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] FRAME_W_C = 10'(FRAME_W);
    localparam logic [8:0] FRAME_H_C = 9'(FRAME_H);
    localparam logic [9:0] X_MAX     = 10'd1023;
    localparam logic [8:0] Y_MAX     = 9'd511;

    typedef struct packed {
        logic [7:0] d;
        logic       vsync;
        logic       href;
        logic       pclk;
    } cam_t;

    typedef enum logic [1:0] {
        WAIT_VS,
        VBLANK,
        ACTIVE
    } state_t;

    cam_t   sync_q [SYNC_STAGES];
    cam_t   cam_s;
    logic   pclk_prev_q;
    logic   href_prev_q;
    logic   vsync_prev_q;
    logic   pclk_rise;
    logic   href_fall;
    logic   vs_rise;
    logic   vs_fall;

    state_t     state_q;
    logic       phase_q;
    logic [7:0] hi_q;
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic [8:0] y_d;
    logic       line_err_q;
    logic       line_err_d;

    logic       pix_valid_q;
    logic [4:0] pix_r_q;
    logic [5:0] pix_g_q;
    logic [4:0] pix_b_q;
    logic [9:0] pix_x_q;
    logic [8:0] pix_y_q;
    logic       frame_start_q;
    logic       line_end_q;
    logic       frame_end_q;
    logic       frame_ok_q;
    logic [7:0] frame_cnt_q;

    // All camera pins share one chain so data stays aligned with its PCLK edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchronizer is a handful of flops, not a RAM, so resetting it is cheap and keeps edges clean after reset.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            pclk_prev_q  <= 1'b0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else if (ena) begin
            // NOTE: non-blocking assignments make every stage sample the old value of its neighbour, forming a true shift chain.
            sync_q[0] <= {cam_d, cam_vsync, cam_href, cam_pclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            pclk_prev_q  <= cam_s.pclk;
            href_prev_q  <= cam_s.href;
            vsync_prev_q <= cam_s.vsync;
        end
    end

    assign cam_s     = sync_q[SYNC_STAGES-1];
    assign pclk_rise = cam_s.pclk & ~pclk_prev_q;
    assign href_fall = ~cam_s.href & href_prev_q;
    assign vs_rise   = cam_s.vsync & ~vsync_prev_q;
    assign vs_fall   = ~cam_s.vsync & vsync_prev_q;

    // Line bookkeeping resolved first so a coincident vs_rise sees the finished line.
    always_comb begin
        // NOTE: defaults before any condition keep this block free of inferred latches.
        line_err_d = line_err_q;
        y_d        = y_q;
        if (href_fall) begin
            if (x_q != FRAME_W_C || phase_q) line_err_d = 1'b1;
            if (y_q != Y_MAX) y_d = y_q + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_VS;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            line_err_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (!ena) begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            case (state_q)
                WAIT_VS: begin
                    if (vs_rise) state_q <= VBLANK;
                end
                VBLANK: begin
                    if (vs_fall) begin
                        frame_start_q <= 1'b1;
                        line_err_q    <= 1'b0;
                        x_q           <= '0;
                        y_q           <= '0;
                        phase_q       <= 1'b0;
                        state_q       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pclk_rise && cam_s.href) begin
                        if (!phase_q) begin
                            hi_q    <= cam_s.d;
                            phase_q <= 1'b1;
                        end else begin
                            pix_valid_q <= 1'b1;
                            pix_r_q     <= hi_q[7:3];
                            pix_g_q     <= {hi_q[2:0], cam_s.d[7:5]};
                            pix_b_q     <= cam_s.d[4:0];
                            pix_x_q     <= x_q;
                            pix_y_q     <= y_q;
                            phase_q     <= 1'b0;
                            if (x_q != X_MAX) x_q <= x_q + 10'd1;
                        end
                    end
                    if (href_fall) begin
                        line_end_q <= 1'b1;
                        x_q        <= '0;
                        phase_q    <= 1'b0;
                    end
                    line_err_q <= line_err_d;
                    y_q        <= y_d;
                    if (vs_rise) begin
                        frame_end_q <= 1'b1;
                        frame_ok_q  <= !line_err_d && (y_d == FRAME_H_C);
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= VBLANK;
                    end
                end
                default: state_q <= WAIT_VS;
            endcase
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign line_end    = line_end_q;
    assign frame_end   = frame_end_q;
    assign frame_ok    = frame_ok_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture: drives a modelled OV7670 bus and compares
// pixel stream and frame results against a frame-level reference model.
module tb_ov7670_pixel_capture;

    localparam int SYNC_STAGES = 2;
    localparam int FRAME_W     = 4;
    localparam int FRAME_H     = 2;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        logic [9:0] x;
        logic [8:0] y;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] cam_d = '0;
    logic       cam_pclk = 1'b0;
    logic       cam_href = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       pix_valid;
    logic [4:0] pix_r;
    logic [5:0] pix_g;
    logic [4:0] pix_b;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       frame_start;
    logic       line_end;
    logic       frame_end;
    logic       frame_ok;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    ov7670_pixel_capture #(
        .SYNC_STAGES(SYNC_STAGES),
        .FRAME_W    (FRAME_W),
        .FRAME_H    (FRAME_H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cam_d      (cam_d),
        .cam_pclk   (cam_pclk),
        .cam_href   (cam_href),
        .cam_vsync  (cam_vsync),
        .pix_valid  (pix_valid),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_start(frame_start),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .frame_ok   (frame_ok),
        .frame_cnt  (frame_cnt)
    );

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    // Frame under construction: flat byte list plus per-line byte counts.
    logic [7:0] fbytes[$];
    int         flen[$];

    // Output monitor, sampled 1 time unit after each rising clk edge.
    pix_t       obs_pix[$];
    pix_t       mon_p;
    int         n_line_end = 0;
    int         n_frame_start = 0;
    int         n_frame_end = 0;
    int         n_hold_pulse = 0;
    int         n_wide_pulse = 0;
    int         n_unstable = 0;
    logic [3:0] mon_pulses;
    logic [3:0] mon_prev_pulses = '0;
    logic       mon_prev_ok = 1'b0;
    logic [7:0] mon_prev_cnt = '0;

    always begin
        @(posedge clk);
        #1;
        mon_pulses = {pix_valid, frame_start, line_end, frame_end};
        if (pix_valid) begin
            mon_p.r = pix_r;
            mon_p.g = pix_g;
            mon_p.b = pix_b;
            mon_p.x = pix_x;
            mon_p.y = pix_y;
            obs_pix.push_back(mon_p);
        end
        if (line_end) n_line_end++;
        if (frame_start) n_frame_start++;
        if (frame_end) n_frame_end++;
        if (!ena && mon_pulses != 4'b0) n_hold_pulse++;
        if ((mon_pulses & mon_prev_pulses) != 4'b0) n_wide_pulse++;
        if (rst_n && !frame_end && (frame_ok !== mon_prev_ok || frame_cnt !== mon_prev_cnt))
            n_unstable++;
        mon_prev_pulses = mon_pulses;
        mon_prev_ok     = frame_ok;
        mon_prev_cnt    = frame_cnt;
    end

    // One PCLK period = 4 clk; called and returning at a falling clk edge.
    task automatic pclk_cycle(input logic [7:0] d, input logic href);
        cam_pclk = 1'b0;
        cam_d    = d;
        cam_href = href;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) pclk_cycle(8'($urandom), 1'b0);
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        blank(4);
        cam_vsync = 1'b0;
        blank(3);
    endtask

    task automatic add_line(input int n, input logic rnd);
        for (int k = 0; k < n; k++)
            fbytes.push_back(rnd ? 8'($urandom) : ((k % 2 == 0) ? 8'hF8 : 8'h1F));
        flen.push_back(n);
    endtask

    task automatic enable_hold();
        cam_pclk = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cam_d = 8'($urandom);
            @(negedge clk);
        end
        ena = 1'b1;
    endtask

    task automatic send_frame(input logic simul, input int hold_at);
        int idx;
        idx = 0;
        for (int l = 0; l < flen.size(); l++) begin
            for (int k = 0; k < flen[l]; k++) begin
                if (idx == hold_at) enable_hold();
                pclk_cycle(fbytes[idx], 1'b1);
                idx++;
            end
            if (!(simul && l == flen.size() - 1)) blank(2);
        end
        vsync_pulse();
    endtask

    // Sends the queued frame, closes it with a VSYNC pulse and scores it.
    task automatic run_frame(input string name, input logic simul, input int hold_at);
        pix_t        exp_pix[$];
        pix_t        p;
        pix_t        got;
        logic [15:0] rgb;
        logic        exp_ok;
        int          idx;
        int          pix_base;
        int          le_base;
        int          fs_base;
        int          fe_base;
        int          hp_base;
        int          got_n;

        exp_ok = (flen.size() == FRAME_H);
        idx = 0;
        for (int l = 0; l < flen.size(); l++) begin
            if (flen[l] != 2 * FRAME_W) exp_ok = 1'b0;
            for (int k = 0; k < flen[l] / 2; k++) begin
                rgb = {fbytes[idx + 2*k], fbytes[idx + 2*k + 1]};
                p.r = 5'(rgb >> 11);
                p.g = 6'((rgb >> 5) & 16'h003F);
                p.b = 5'(rgb & 16'h001F);
                p.x = 10'((k > 1023) ? 1023 : k);
                p.y = 9'((l > 511) ? 511 : l);
                exp_pix.push_back(p);
            end
            idx += flen[l];
        end

        pix_base = obs_pix.size();
        le_base  = n_line_end;
        fs_base  = n_frame_start;
        fe_base  = n_frame_end;
        hp_base  = n_hold_pulse;
        send_frame(simul, hold_at);
        model_cnt++;

        got_n = obs_pix.size() - pix_base;
        total++;
        if (got_n !== exp_pix.size()) begin
            bad++;
            $display("FAIL %s pixel count: got %0d want %0d", name, got_n, exp_pix.size());
        end
        for (int i = 0; i < exp_pix.size() && i < got_n; i++) begin
            got = obs_pix[pix_base + i];
            total++;
            if (got !== exp_pix[i]) begin
                bad++;
                $display("FAIL %s pix[%0d]: got r=%0d g=%0d b=%0d x=%0d y=%0d want r=%0d g=%0d b=%0d x=%0d y=%0d",
                         name, i, got.r, got.g, got.b, got.x, got.y,
                         exp_pix[i].r, exp_pix[i].g, exp_pix[i].b, exp_pix[i].x, exp_pix[i].y);
            end
        end
        total++;
        if (n_line_end - le_base !== flen.size()) begin
            bad++;
            $display("FAIL %s line_end count: got %0d want %0d", name, n_line_end - le_base, flen.size());
        end
        total++;
        if (n_frame_end - fe_base !== 1) begin
            bad++;
            $display("FAIL %s frame_end count: got %0d want 1", name, n_frame_end - fe_base);
        end
        total++;
        if (n_frame_start - fs_base !== 1) begin
            bad++;
            $display("FAIL %s frame_start count: got %0d want 1", name, n_frame_start - fs_base);
        end
        total++;
        if (frame_ok !== exp_ok) begin
            bad++;
            $display("FAIL %s frame_ok: got %0b want %0b", name, frame_ok, exp_ok);
        end
        total++;
        if (frame_cnt !== 8'(model_cnt)) begin
            bad++;
            $display("FAIL %s frame_cnt: got %0d want %0d", name, frame_cnt, 8'(model_cnt));
        end
        if (hold_at >= 0) begin
            total++;
            if (n_hold_pulse - hp_base !== 0) begin
                bad++;
                $display("FAIL %s pulses while ena low: got %0d want 0", name, n_hold_pulse - hp_base);
            end
        end
        fbytes.delete();
        flen.delete();
    endtask

    task automatic test_reset();
        int pix_base;
        int fs_base;
        ena   = 1'b1;
        rst_n = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cam_d     = 8'($urandom);
            cam_pclk  = 1'($urandom);
            cam_href  = 1'($urandom);
            cam_vsync = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if ({pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, frame_start, line_end,
                 frame_end, frame_ok, frame_cnt} !== 48'd0) begin
                bad++;
                $display("FAIL reset outputs cycle %0d: got pv=%0b x=%0d y=%0d ok=%0b cnt=%0d want all 0",
                         i, pix_valid, pix_x, pix_y, frame_ok, frame_cnt);
            end
        end
        @(negedge clk);
        cam_pclk  = 1'b0;
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        rst_n     = 1'b1;
        pix_base  = obs_pix.size();
        fs_base   = n_frame_start;
        for (int i = 0; i < 6; i++) pclk_cycle(8'($urandom), 1'b1);
        blank(2);
        total++;
        if (obs_pix.size() - pix_base !== 0 || n_frame_start - fs_base !== 0) begin
            bad++;
            $display("FAIL reset no-vsync activity: got pixels=%0d frame_start=%0d want 0 0",
                     obs_pix.size() - pix_base, n_frame_start - fs_base);
        end
        vsync_pulse();
        total++;
        if (n_frame_start - fs_base !== 1) begin
            bad++;
            $display("FAIL reset first frame_start: got %0d want 1", n_frame_start - fs_base);
        end
    endtask

    task automatic test_clean_frame();
        add_line(2 * FRAME_W, 1'b0);
        add_line(2 * FRAME_W, 1'b0);
        run_frame("clean", 1'b0, -1);
    endtask

    task automatic test_short_line();
        add_line(2 * FRAME_W, 1'b0);
        add_line(2 * FRAME_W - 2, 1'b0);
        run_frame("short_line", 1'b0, -1);
        add_line(2 * FRAME_W, 1'b0);
        add_line(2 * FRAME_W, 1'b0);
        run_frame("after_short", 1'b0, -1);
    endtask

    task automatic test_odd_and_count();
        add_line(2 * FRAME_W + 1, 1'b1);
        add_line(2 * FRAME_W, 1'b1);
        run_frame("odd_bytes", 1'b0, -1);
        for (int l = 0; l < FRAME_H + 1; l++) add_line(2 * FRAME_W, 1'b1);
        run_frame("extra_line", 1'b0, -1);
        add_line(2 * FRAME_W + 4, 1'b1);
        add_line(2 * FRAME_W, 1'b1);
        run_frame("overlong", 1'b0, -1);
    endtask

    task automatic test_simultaneous();
        add_line(2 * FRAME_W, 1'b1);
        add_line(2 * FRAME_W, 1'b1);
        run_frame("href_fall_with_vs_rise", 1'b1, -1);
    endtask

    task automatic test_random_frames();
        int opts[6];
        int nl;
        opts = '{2 * FRAME_W, 2 * FRAME_W, 2 * FRAME_W - 2, 2 * FRAME_W + 2, 2 * FRAME_W + 1, 1};
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(0, 3);
            for (int l = 0; l < nl; l++) add_line(opts[$urandom_range(0, 5)], 1'b1);
            run_frame($sformatf("random%0d", f), 1'($urandom_range(0, 1)), -1);
        end
    endtask

    task automatic test_enable_hold();
        add_line(2 * FRAME_W, 1'b1);
        add_line(2 * FRAME_W, 1'b1);
        run_frame("enable_hold", 1'b0, 3);
    endtask

    task automatic test_midframe_reset();
        int pix_base;
        int fs_base;
        for (int i = 0; i < 3; i++) pclk_cycle(8'($urandom), 1'b1);
        rst_n = 1'b0;
        #1;
        total++;
        if ({pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, frame_start, line_end,
             frame_end, frame_ok, frame_cnt} !== 48'd0) begin
            bad++;
            $display("FAIL midframe reset clear: got x=%0d y=%0d ok=%0b cnt=%0d want all 0",
                     pix_x, pix_y, frame_ok, frame_cnt);
        end
        model_cnt = 0;
        for (int i = 0; i < 2; i++) pclk_cycle(8'($urandom), 1'b1);
        rst_n    = 1'b1;
        pix_base = obs_pix.size();
        fs_base  = n_frame_start;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 2 * FRAME_W; i++) pclk_cycle(8'($urandom), 1'b1);
            blank(2);
        end
        total++;
        if (obs_pix.size() - pix_base !== 0 || n_frame_start - fs_base !== 0) begin
            bad++;
            $display("FAIL startup mid-frame: got pixels=%0d frame_start=%0d want 0 0",
                     obs_pix.size() - pix_base, n_frame_start - fs_base);
        end
        vsync_pulse();
        total++;
        if (n_frame_start - fs_base !== 1) begin
            bad++;
            $display("FAIL startup frame_start after vsync: got %0d want 1", n_frame_start - fs_base);
        end
        add_line(2 * FRAME_W, 1'b0);
        add_line(2 * FRAME_W, 1'b0);
        run_frame("after_reset", 1'b0, -1);
    endtask

    task automatic test_cnt_wrap();
        int fe_base;
        fe_base = n_frame_end;
        for (int f = 0; f < 256; f++) begin
            vsync_pulse();
            model_cnt++;
        end
        total++;
        if (n_frame_end - fe_base !== 256) begin
            bad++;
            $display("FAIL wrap frame_end count: got %0d want 256", n_frame_end - fe_base);
        end
        total++;
        if (frame_cnt !== 8'(model_cnt)) begin
            bad++;
            $display("FAIL wrap frame_cnt: got %0d want %0d", frame_cnt, 8'(model_cnt));
        end
        total++;
        if (frame_ok !== 1'b0) begin
            bad++;
            $display("FAIL wrap empty frame_ok: got %0b want 0", frame_ok);
        end
    endtask

    task automatic test_pulse_shape();
        total++;
        if (n_wide_pulse !== 0) begin
            bad++;
            $display("FAIL pulse width: got %0d multi-cycle pulses want 0", n_wide_pulse);
        end
        total++;
        if (n_unstable !== 0) begin
            bad++;
            $display("FAIL frame_ok/frame_cnt stability: got %0d changes outside frame_end want 0", n_unstable);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_short_line();
        test_odd_and_count();
        test_simultaneous();
        test_random_frames();
        test_enable_hold();
        test_midframe_reset();
        test_cnt_wrap();
        test_pulse_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
